// File: rtl/alu_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mult_seq
//  Description : Multi-cycle shift-and-add multiply sequencer. Produces the
//                low 16 bits of a 16x16 product by time-sharing an external
//                16-bit combinational ALU (add / shift-left / shift-right).
//                While busy it owns the ALU operand and op inputs; otherwise
//                it drives them to a quiet add of zero and zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mult_seq (
    input  logic        clk,
    input  logic        rst,        // synchronous, active-low
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic [2:0]  alu_Op,
    output logic        alu_Cin,
    output logic        alu_invA,
    output logic        alu_invB,
    output logic        alu_sign,
    input  logic [15:0] alu_Out
);

    // ------------------------------------------------------------------------
    // ALU op encodings and fixed operands
    // ------------------------------------------------------------------------
    localparam logic [2:0]  c_OP_ADD = 3'b100;
    localparam logic [2:0]  c_OP_SLL = 3'b001;
    localparam logic [2:0]  c_OP_SRL = 3'b011;
    localparam logic [15:0] c_ONE    = 16'h0001;
    localparam logic [15:0] c_ZERO   = 16'h0000;
    localparam logic [4:0]  c_BITS   = 5'd16;

    // ------------------------------------------------------------------------
    // Sequencer states
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EVAL = 3'd1,
        S_ADD  = 3'd2,
        S_SHL  = 3'd3,
        S_SHR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_acc;      // running partial product
    logic [15:0] r_mcand;    // multiplicand, shifted left one bit per step
    logic [15:0] r_mplier;   // multiplier, shifted right one bit per step
    logic [4:0]  r_cnt;      // number of multiplier bits consumed
    logic [15:0] r_product;  // result, held until the next accepted start

    // The loop ends early once all remaining multiplier bits are zero, so
    // short multipliers finish quickly; the bit counter bounds the worst case.
    logic        w_eval_finish;

    assign w_eval_finish = (r_mplier == c_ZERO) || (r_cnt == c_BITS);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Advance the sequencer one state per clock; reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and ALU drive logic
    // ------------------------------------------------------------------------
    // Choose the next step and steer the shared ALU for the current step.
    always_comb begin
        w_next_state = r_state;
        alu_A        = c_ZERO;
        alu_B        = c_ZERO;
        alu_Op       = c_OP_ADD;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_EVAL;
                end
            end

            S_EVAL: begin
                if (w_eval_finish) begin
                    w_next_state = S_DONE;
                end else if (r_mplier[0]) begin
                    w_next_state = S_ADD;
                end else begin
                    w_next_state = S_SHL;
                end
            end

            S_ADD: begin
                alu_A        = r_acc;
                alu_B        = r_mcand;
                alu_Op       = c_OP_ADD;
                w_next_state = S_SHL;
            end

            S_SHL: begin
                alu_A        = r_mcand;
                alu_B        = c_ONE;
                alu_Op       = c_OP_SLL;
                w_next_state = S_SHR;
            end

            S_SHR: begin
                alu_A        = r_mplier;
                alu_B        = c_ONE;
                alu_Op       = c_OP_SRL;
                w_next_state = S_EVAL;
            end

            S_DONE: begin
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Load operands on an accepted start, then capture ALU results per step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc     <= c_ZERO;
            r_mcand   <= c_ZERO;
            r_mplier  <= c_ZERO;
            r_cnt     <= 5'd0;
            r_product <= c_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= c_ZERO;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_cnt    <= 5'd0;
                    end
                end

                S_EVAL: begin
                    if (w_eval_finish) begin
                        r_product <= r_acc;
                    end
                end

                S_ADD: begin
                    r_acc <= alu_Out;
                end

                S_SHL: begin
                    r_mcand <= alu_Out;
                end

                S_SHR: begin
                    r_mplier <= alu_Out;
                    r_cnt    <= r_cnt + 5'd1;
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status and fixed ALU controls
    // ------------------------------------------------------------------------
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign product  = r_product;

    // Plain unsigned arithmetic only: no carry-in, no inversion, no sign mode.
    assign alu_Cin  = 1'b0;
    assign alu_invA = 1'b0;
    assign alu_invB = 1'b0;
    assign alu_sign = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mult_seq
//  Description : Self-checking bench for alu_mult_seq. Provides a reference
//                combinational ALU, applies a table of directed multiplies
//                and a few hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [2:0]  alu_Op;
    logic        alu_Cin;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_sign;
    logic [15:0] alu_Out;

    int checks   = 0;
    int failures = 0;
    bit side_err = 1'b0;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] exp_prod;
        int          exp_lat;    // edges from accept to DONE entry
        int          exp_shift;  // number of SHL (and SHR) steps
    } vec_t;

    vec_t vecs [12];

    alu_mult_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_Op   (alu_Op),
        .alu_Cin  (alu_Cin),
        .alu_invA (alu_invA),
        .alu_invB (alu_invB),
        .alu_sign (alu_sign),
        .alu_Out  (alu_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: add, logical left shift, logical right shift by B[3:0].
    always_comb begin
        case (alu_Op)
            3'b100:  alu_Out = alu_A + alu_B;
            3'b001:  alu_Out = alu_A << alu_B[3:0];
            3'b011:  alu_Out = alu_A >> alu_B[3:0];
            default: alu_Out = 16'h0000;
        endcase
    end

    // The fixed ALU controls must never be asserted.
    always @(negedge clk) begin
        if (alu_Cin || alu_invA || alu_invB || alu_sign) side_err = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for done after an accept edge; returns edges counted, op tallies
    // and whether busy/done misbehaved before the done pulse.
    task automatic wait_done(input int limit, output int lat, output int n_shl,
                             output int n_shr, output bit early_bad);
        lat = -1; n_shl = 0; n_shr = 0; early_bad = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (alu_Op == 3'b001) n_shl++;
            if (alu_Op == 3'b011) n_shr++;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) early_bad = 1'b1;
        end
    endtask

    // Full transaction: present a/b with a one-cycle start, scramble inputs
    // after acceptance, then check latency, product, op counts and wind-down.
    task automatic run_vec(input vec_t v, input int idx);
        int lat, n_shl, n_shr;
        bit early_bad;
        @(negedge clk);
        a = v.va; b = v.vb; start = 1'b1;
        @(posedge clk); #1;
        check($sformatf("v%0d_busy_after_accept", idx), {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0; a = ~v.va; b = ~v.vb;
        wait_done(100, lat, n_shl, n_shr, early_bad);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_product", idx), {16'd0, product}, {16'd0, v.exp_prod});
        check($sformatf("v%0d_shl_count", idx), n_shl, v.exp_shift);
        check($sformatf("v%0d_shr_count", idx), n_shr, v.exp_shift);
        check($sformatf("v%0d_busy_before_done", idx), {31'd0, early_bad}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_idle_after", idx), {30'd0, busy, done}, 32'd0);
        check($sformatf("v%0d_product_held", idx), {16'd0, product}, {16'd0, v.exp_prod});
        check($sformatf("v%0d_idle_alu", idx), {alu_A, alu_B[12:0], alu_Op}, {29'd0, 3'b100});
    endtask

    initial begin
        int lat, n_shl, n_shr;
        bit early_bad;

        //              a         b         product   lat shifts
        vecs[0]  = '{16'h0003, 16'h0005, 16'h000F, 12,  3};
        vecs[1]  = '{16'h1234, 16'h0000, 16'h0000,  1,  0};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 16'h0001, 65, 16};
        vecs[3]  = '{16'hFFFD, 16'h0007, 16'hFFEB, 13,  3};
        vecs[4]  = '{16'h0009, 16'h0009, 16'h0051, 15,  4};
        vecs[5]  = '{16'h0006, 16'h0006, 16'h0024, 12,  3};
        vecs[6]  = '{16'h0100, 16'h0100, 16'h0000, 29,  9};
        vecs[7]  = '{16'h00FF, 16'h0002, 16'h01FE,  8,  2};
        vecs[8]  = '{16'h8000, 16'h8000, 16'h0000, 50, 16};
        vecs[9]  = '{16'h1234, 16'h0001, 16'h1234,  5,  1};
        vecs[10] = '{16'h0007, 16'hFFFF, 16'hFFF9, 65, 16};
        vecs[11] = '{16'h0000, 16'h00F0, 16'h0000, 29,  8};

        rst = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_product", {16'd0, product}, 32'd0);
        check("reset_alu_drive", {alu_A, alu_B[12:0], alu_Op}, {29'd0, 3'b100});
        @(negedge clk);
        rst = 1'b1;

        // Table-driven directed multiplies.
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Start during busy is ignored: 9*9 with a second start at edge 3.
        @(negedge clk);
        a = 16'd9; b = 16'd9; start = 1'b1;
        @(posedge clk);                      // accept edge
        @(negedge clk); start = 1'b0;
        @(posedge clk);                      // edge 1
        @(posedge clk);                      // edge 2
        @(negedge clk); start = 1'b1; a = 16'd2; b = 16'd2;
        @(posedge clk);                      // edge 3, must be ignored
        @(negedge clk); start = 1'b0;
        wait_done(100, lat, n_shl, n_shr, early_bad);
        check("busy_start_latency", lat + 3, 15);
        check("busy_start_product", {16'd0, product}, 32'h51);

        // Reset mid-operation aborts with no done and clears product.
        @(posedge clk);
        @(negedge clk);
        a = 16'd6; b = 16'd6; start = 1'b1;
        @(posedge clk);                      // accept edge
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);           // edges 1..4
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;                  // edge 5 under reset
        check("midreset_busy_done", {30'd0, busy, done}, 32'd0);
        check("midreset_product", {16'd0, product}, 32'd0);
        @(negedge clk); rst = 1'b1;
        begin
            bit saw_done = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (done || busy) saw_done = 1'b1;
            end
            check("midreset_no_done", {31'd0, saw_done}, 32'd0);
        end
        run_vec(vecs[5], 100);

        // Back-to-back: start held high; second start accepted in the IDLE
        // cycle after DONE, with a/b changed right after the first accept.
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        @(posedge clk);                      // first accept
        @(negedge clk); a = 16'd4; b = 16'd3;
        wait_done(100, lat, n_shl, n_shr, early_bad);
        check("b2b_first_latency", lat, 12);
        check("b2b_first_product", {16'd0, product}, 32'h0F);
        @(posedge clk); #1;                  // DONE -> IDLE, start ignored in DONE
        check("b2b_idle_gap", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;                  // accepted in IDLE
        check("b2b_second_accept", {31'd0, busy}, 32'd1);
        check("b2b_product_held", {16'd0, product}, 32'h0F);
        @(negedge clk); start = 1'b0;
        wait_done(100, lat, n_shl, n_shr, early_bad);
        check("b2b_second_latency", lat, 9);
        check("b2b_second_product", {16'd0, product}, 32'h0C);

        check("fixed_alu_controls", {31'd0, side_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
